// File: rtl/parking_exit_gate.sv
// rtl/parking_exit_gate.sv - exit barrier controller owning lot occupancy and free-space display
module parking_exit_gate #(
  parameter int         CAPACITY    = 20,
  parameter int         WAIT_CYCLES = 3,
  parameter logic [1:0] EXIT_CODE_1 = 2'b01,
  parameter logic [1:0] EXIT_CODE_2 = 2'b10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sensor_exit,
  input  logic       car_entered,
  input  logic [1:0] exit_code_1,
  input  logic [1:0] exit_code_2,
  output logic       GREEN_LED,
  output logic       RED_LED,
  output logic [6:0] HEX_1,
  output logic [6:0] HEX_2,
  output logic       car_left,
  output logic       lot_full
);

  localparam int OW = $clog2(CAPACITY + 1);
  localparam int WW = $clog2(WAIT_CYCLES + 1);
  localparam logic [3:0] CAP_TENS  = 4'(CAPACITY / 10);
  localparam logic [3:0] CAP_UNITS = 4'(CAPACITY % 10);

  typedef enum logic [1:0] {IDLE, WAIT_CODE, WRONG_CODE, OPEN} state_t;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  state_t        state_q, state_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic [OW-1:0] occ_q, occ_d;
  logic          green_q, green_d, red_q, red_d, car_left_q, car_left_d, lot_full_q;
  logic [6:0]    hex1_q, hex2_q;
  logic          match_w, inc_w, dec_w;
  logic [6:0]    free_w, tens_w, units_w;

  assign match_w = (exit_code_1 == EXIT_CODE_1) && (exit_code_2 == EXIT_CODE_2);

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    green_d    = 1'b0;
    red_d      = 1'b0;
    car_left_d = 1'b0;
    dec_w      = 1'b0;
    case (state_q)
      IDLE: begin
        if (sensor_exit && (occ_q != '0)) begin
          state_d    = WAIT_CODE;
          wait_cnt_d = '0;
          red_d      = 1'b1;
        end
      end
      WAIT_CODE: begin
        red_d = 1'b1;
        if (!sensor_exit) begin
          state_d = IDLE;
          red_d   = 1'b0;
        end else if (wait_cnt_q == WW'(WAIT_CYCLES - 1)) begin
          state_d = match_w ? OPEN : WRONG_CODE;
          green_d = match_w;
          red_d   = !match_w;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      WRONG_CODE: begin
        if (!sensor_exit) begin
          state_d = IDLE;
        end else if (match_w) begin
          state_d = OPEN;
          green_d = 1'b1;
        end else begin
          red_d = !red_q;
        end
      end
      OPEN: begin
        green_d = 1'b1;
        if (!sensor_exit) begin
          state_d    = IDLE;
          green_d    = 1'b0;
          car_left_d = 1'b1;
          dec_w      = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A pulse arriving while full is dropped, even if a car leaves that same cycle.
  always_comb begin
    inc_w = car_entered && (occ_q != OW'(CAPACITY));
    occ_d = occ_q;
    if (inc_w && !dec_w)      occ_d = occ_q + 1'b1;
    else if (dec_w && !inc_w) occ_d = occ_q - 1'b1;
    free_w  = 7'(CAPACITY) - 7'(occ_q);
    tens_w  = free_w / 7'd10;
    units_w = free_w % 7'd10;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      occ_q      <= '0;
      green_q    <= 1'b0;
      red_q      <= 1'b0;
      car_left_q <= 1'b0;
      lot_full_q <= 1'b0;
      hex1_q     <= seg7(CAP_TENS);
      hex2_q     <= seg7(CAP_UNITS);
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      occ_q      <= occ_d;
      green_q    <= green_d;
      red_q      <= red_d;
      car_left_q <= car_left_d;
      lot_full_q <= (occ_d == OW'(CAPACITY));
      hex1_q     <= seg7(tens_w[3:0]);
      hex2_q     <= seg7(units_w[3:0]);
    end
  end

  assign GREEN_LED = green_q;
  assign RED_LED   = red_q;
  assign car_left  = car_left_q;
  assign lot_full  = lot_full_q;
  assign HEX_1     = hex1_q;
  assign HEX_2     = hex2_q;

endmodule
